// File: rtl/mem_refill_responder.sv
// rtl/mem_refill_responder.sv - cache refill memory responder with fixed read latency
//
// Single-port word memory (2**ADDR_WIDTH x 32) serving cache refill reads
// with a fixed LATENCY-cycle response and single-cycle writes.
//
// Optional feature macro: MEM_RESP_RANGE_CHECK_EN
//   defined   : out-of-range reads return 0 with oError, out-of-range writes dropped
//   undefined : no oError port, address wraps modulo the memory size
//
// Ports:
//   iCLK        clock
//   iRSTn       asynchronous active-low reset
//   iReadReq    refill read request, accepted when oReady
//   iWriteReq   single-word write request, accepted when oReady
//   iAddress    byte address, bits [1:0] ignored
//   iWriteData  write data
//   oReady      responder idle, requests accepted this cycle
//   oDataValid  one-cycle pulse qualifying oData
//   oData       read data, held between pulses
//   oError      out-of-range read flag (MEM_RESP_RANGE_CHECK_EN only)

module mem_refill_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic        iCLK,
    input  logic        iRSTn,
    input  logic        iReadReq,
    input  logic        iWriteReq,
    input  logic [31:0] iAddress,
    input  logic [31:0] iWriteData,
    output logic        oReady,
    output logic        oDataValid,
    output logic [31:0] oData
`ifdef MEM_RESP_RANGE_CHECK_EN
    ,
    output logic        oError
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           mem [DEPTH];
    state_t                state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] rd_idx_q;
    logic                  rd_oor_q;

    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  req_oor;
    logic                  wr_en;
    logic [31:0]           wait_rdata;
    logic [31:0]           fwd_rdata;
    logic                  unused_addr_bits;

    assign req_idx = iAddress[ADDR_WIDTH+1:2];

`ifdef MEM_RESP_RANGE_CHECK_EN
    assign req_oor          = |iAddress[31:ADDR_WIDTH+2];
    assign unused_addr_bits = ^iAddress[1:0];
`else
    assign req_oor          = 1'b0;
    assign unused_addr_bits = ^{iAddress[31:ADDR_WIDTH+2], iAddress[1:0]};
`endif

    assign oReady = (state == IDLE);

    // Writes are only taken while idle and out of reset; out-of-range writes
    // are dropped (req_oor is constant 0 without range checking).
    assign wr_en = iRSTn && oReady && iWriteReq && !req_oor;

    always_ff @(posedge iCLK) begin
        if (wr_en) begin
            mem[req_idx] <= iWriteData;
        end
    end

    assign wait_rdata = rd_oor_q ? 32'd0 : mem[rd_idx_q];

    // With LATENCY=1 the response is captured on the same edge as the
    // accepted write, so a simultaneous write (same address by construction)
    // must be forwarded instead of reading the stale array word.
    assign fwd_rdata = req_oor ? 32'd0 : (wr_en ? iWriteData : mem[req_idx]);

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            rd_idx_q   <= '0;
            rd_oor_q   <= 1'b0;
            oDataValid <= 1'b0;
            oData      <= 32'd0;
`ifdef MEM_RESP_RANGE_CHECK_EN
            oError     <= 1'b0;
`endif
        end else begin
            oDataValid <= 1'b0;
`ifdef MEM_RESP_RANGE_CHECK_EN
            oError     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (iReadReq) begin
                        rd_idx_q <= req_idx;
                        rd_oor_q <= req_oor;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            oDataValid <= 1'b1;
                            oData      <= fwd_rdata;
`ifdef MEM_RESP_RANGE_CHECK_EN
                            oError     <= req_oor;
`endif
                        end else begin
                            cnt   <= 4'(LATENCY - 1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Counter reaches zero on the edge that enters RESP, so the
                    // response lands LATENCY cycles after the accept edge.
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        cnt        <= 4'd0;
                        state      <= RESP;
                        oDataValid <= 1'b1;
                        oData      <= wait_rdata;
`ifdef MEM_RESP_RANGE_CHECK_EN
                        oError     <= rd_oor_q;
`endif
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_refill_responder.md
MEM_REFILL_RESPONDER -- requirements
Module: mem_refill_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word-address bits of the backing store (2**ADDR_WIDTH 32-bit words).
REQ-002 Parameter LATENCY, default 4, cycles from request accept to read response; legal range 1..15.
REQ-003 iCLK  input  1  single clock; all state updates on posedge iCLK.
REQ-004 iRSTn  input  1  reset, asynchronous, active-low.
REQ-005 iReadReq  input  1  cache miss refill request; qualified by oReady.
REQ-006 iWriteReq  input  1  single-word write request; qualified by oReady.
REQ-007 iAddress  input  32  byte address for read or write; bits [1:0] ignored.
REQ-008 iWriteData  input  32  write data.
REQ-009 oReady  output  1  responder idle; requests accepted this cycle.
REQ-010 oDataValid  output  1  one-cycle pulse marking valid oData.
REQ-011 oData  output  32  refill data returned to the cache.
REQ-012 oError  output  1  out-of-range flag; present only with MEM_RESP_RANGE_CHECK_EN.

Function
REQ-013 FSM states: IDLE, WAIT, RESP; oReady SHALL be 1 only in IDLE.
REQ-014 Word index SHALL be iAddress[ADDR_WIDTH+1:2].
REQ-015 IDLE with iReadReq=1: latch word index; load counter with LATENCY-1; go to WAIT, or to RESP directly if LATENCY=1.
REQ-016 WAIT: decrement counter each cycle; at counter==0 move to RESP.
REQ-017 RESP: oDataValid=1 and oData=memory[latched index] for exactly one cycle; next state IDLE.
REQ-018 Read accepted at edge N SHALL have oDataValid high in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after acceptance.
REQ-019 oData SHALL hold its last value while oDataValid=0.
REQ-020 IDLE with iWriteReq=1: memory[index] <= iWriteData at that edge; FSM stays IDLE unless a read is also present.
REQ-021 Simultaneous iReadReq and iWriteReq in IDLE: both accepted; the write occurs first and the read returns the newly written data.
REQ-022 iReadReq/iWriteReq while oReady=0 SHALL be ignored (no state or memory change); requester must hold until oReady.
REQ-023 Back-to-back reads: a read held high across RESP SHALL be accepted in the following IDLE cycle; minimum request spacing is LATENCY+1 cycles.
REQ-024 Memory contents SHALL be readable the cycle after a write (no read-after-write hazard).

Reset
REQ-025 iRSTn low SHALL asynchronously force state IDLE, counter 0, oDataValid 0, oData 0, oError 0, and oReady 1.
REQ-026 Reset during WAIT or RESP SHALL abort the pending read; no oDataValid pulse after reset release.
REQ-027 Memory array contents SHALL not be cleared by reset.
REQ-028 Requests are accepted from the first posedge iCLK after iRSTn deasserts.

Configuration
REQ-029 Macro MEM_RESP_RANGE_CHECK_EN selects out-of-range checking.
REQ-030 When defined: a read with any iAddress[31:ADDR_WIDTH+2] bit set SHALL complete with normal latency, with oData=0 and oError=1 for the oDataValid cycle; an out-of-range write SHALL be dropped.
REQ-031 When defined: oError SHALL be 0 in every cycle where oDataValid=0.
REQ-032 When not defined: port oError is absent, upper address bits are ignored, and the address wraps modulo the memory size.

Verification
REQ-033 Reset, write 0xDEADBEEF to 0x0000_0010, read 0x0000_0010 at edge N -> oDataValid=1, oData=0xDEADBEEF exactly 4 cycles later, oReady=0 in between.
REQ-034 Simultaneous write 0x12345678 and read at 0x0000_0020 -> response 0x12345678 after LATENCY cycles.
REQ-035 Read held continuously high -> responses every 5 cycles (LATENCY=4); read pulsed while oReady=0 -> no extra response.
REQ-036 Read accepted, iRSTn low for 1 cycle during WAIT -> no oDataValid; oReady=1 and oData=0 after reset.
REQ-037 With MEM_RESP_RANGE_CHECK_EN, read 0x0000_1000 (ADDR_WIDTH=10) -> oError=1, oData=0. Without the macro, the same address aliases word 0 and returns its contents.
REQ-038 LATENCY=1 build: a read accepted at edge N -> oDataValid in the next cycle; back-to-back spacing of 2 cycles.
